klp32_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the KLP32 RV32I core. Drives every CONTROL point of the datapath:
//   - PC select/write, register-file write enable, immgen select
//   - ALU A/B muxes, ALU op, data-memory strobes, writeback mux

---
 rtl/klp32_pkg.sv | 91 +++++++++
 rtl/klp32_if.sv | 28 ++
 rtl/klp32_decode.sv | 77 +++++++
 rtl/klp32_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_klp32_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/klp32_pkg.sv
// Shared types and constants for the KLP32 multi-cycle control path.
// Holds the FSM state encoding, the control-field enums that appear on the
// datapath control ports, the decoded instruction classes, the RV32I base
// opcodes and a helper that maps funct3 (+ alternate bit) to an ALU operation.
package klp32_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [3:0] {
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE,
    CL_OPIMM,
    CL_OP,
    CL_ILLEGAL
  } inst_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ADDI x0,x0,0 -- the instruction register holds this after reset
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored elsewhere
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/klp32_if.sv
// Memory handshake bundle between the KLP32 control FSM and the instruction /
// data memories.
//   imem_inst  [31:0]  instruction word from instruction memory
//   imem_valid         imem_inst valid this cycle
//   imem_req           fetch request
//   dmem_ready         data memory completes the access this cycle
//   dmem_re / dmem_we  load / store strobes
//   mem_funct3 [2:0]   access width and sign (ir[14:12])
// master = control FSM side, slave = memory side.
interface klp32_if;
  logic [31:0] imem_inst;
  logic        imem_valid;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_re;
  logic        dmem_we;
  logic [2:0]  mem_funct3;

  modport master (
    input  imem_inst, imem_valid, dmem_ready,
    output imem_req, dmem_re, dmem_we, mem_funct3
  );

  modport slave (
    output imem_inst, imem_valid, dmem_ready,
    input  imem_req, dmem_re, dmem_we, mem_funct3
  );
endinterface

// File: rtl/klp32_decode.sv
// Combinational instruction decoder for the KLP32 control FSM.
// Inputs : opcode, funct3, funct7 fields of the instruction register.
// Outputs: instruction class, legality, and the class-specific ALU op,
//          immediate format, ALU A/B operand selects and writeback source.
module klp32_decode
  import klp32_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output inst_class_t cls,
  output logic        legal,
  output alu_op_t     alu_sel,
  output imm_sel_t    imm_sel,
  output a_sel_t      a_sel,
  output logic        b_sel,
  output wb_sel_t     wb_sel
);

  always_comb begin
    cls     = CL_ILLEGAL;
    alu_sel = ALU_ADD;
    imm_sel = IMM_I;
    a_sel   = A_RS1;
    b_sel   = 1'b1;
    wb_sel  = WB_ALU;
    case (opcode)
      OPC_LUI: begin
        cls     = CL_LUI;
        imm_sel = IMM_U;
        a_sel   = A_ZERO;
      end
      OPC_AUIPC: begin
        cls     = CL_AUIPC;
        imm_sel = IMM_U;
        a_sel   = A_PC;
      end
      OPC_JAL: begin
        cls     = CL_JAL;
        imm_sel = IMM_J;
        a_sel   = A_PC;
        wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        cls    = CL_JALR;
        wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings
        if (funct3[2:1] != 2'b01) cls = CL_BRANCH;
        imm_sel = IMM_B;
        a_sel   = A_PC;
      end
      OPC_LOAD: begin
        cls    = CL_LOAD;
        wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        cls     = CL_STORE;
        imm_sel = IMM_S;
      end
      OPC_OPIMM: begin
        cls = CL_OPIMM;
        // ADDI has no SUB form; only the right shift looks at funct7[5]
        alu_sel = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_OP: begin
        if (funct7 == 7'h00 || funct7 == 7'h20) cls = CL_OP;
        alu_sel = alu_from_funct3(funct3, funct7[5]);
        b_sel   = 1'b0;
      end
      default: ;
    endcase
    legal = (cls != CL_ILLEGAL);
  end

endmodule

// File: rtl/klp32_multicycle_ctrl.sv
// Multi-cycle control FSM for the KLP32 RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB], holds the
// instruction register, drives every datapath control point and counts
// retired instructions. Waits on either memory are bounded by TIMEOUT_CYCLES;
// a timeout or an illegal instruction parks the FSM in a sticky TRAP state.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem (master)        instruction/data memory handshake bundle
//   ir                  latched instruction
//   br_eq/br_lt/br_ltu  branch comparator results
//   pc_write, pc_sel    PC load enable, 0=PC+4 / 1=ALU result
//   reg_we              register-file write enable
//   imm_sel, a_sel, b_sel, alu_sel, wb_sel   datapath mux/ALU controls
//   retired, instret    retire pulse and retired-instruction count
//   trap                high while in TRAP
module klp32_multicycle_ctrl
  import klp32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  klp32_if.master              mem,
  output logic [31:0]          ir,
  input  logic                 br_eq,
  input  logic                 br_lt,
  input  logic                 br_ltu,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 reg_we,
  output logic [2:0]           imm_sel,
  output logic [1:0]           a_sel,
  output logic                 b_sel,
  output logic [3:0]           alu_sel,
  output logic [1:0]           wb_sel,
  output logic                 retired,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t               state_q, state_d;
  logic [31:0]          ir_q, ir_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  inst_class_t dec_cls;
  logic        dec_legal;
  alu_op_t     dec_alu;
  imm_sel_t    dec_imm;
  a_sel_t      dec_a;
  logic        dec_b;
  wb_sel_t     dec_wb;

  logic waiting;
  logic timeout;
  logic br_taken;

  klp32_decode u_decode (
    .opcode  (ir_q[6:0]),
    .funct3  (ir_q[14:12]),
    .funct7  (ir_q[31:25]),
    .cls     (dec_cls),
    .legal   (dec_legal),
    .alu_sel (dec_alu),
    .imm_sel (dec_imm),
    .a_sel   (dec_a),
    .b_sel   (dec_b),
    .wb_sel  (dec_wb)
  );

  // A handshake in the same cycle as the last allowed wait cycle wins,
  // because waiting is already false when the memory responds.
  assign waiting = ((state_q == ST_FETCH) && !mem.imem_valid) ||
                   ((state_q == ST_MEM)   && !mem.dmem_ready);
  assign timeout = (TIMEOUT_CYCLES != 0) && waiting &&
                   (int'(tmo_q) == TIMEOUT_CYCLES - 1);

  // funct3[2:1] picks the comparison, funct3[0] inverts it
  always_comb begin
    case (ir_q[14:12])
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= NOP_INST;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = '0;
    instret_d = instret_q + INSTRET_W'(retired);
    case (state_q)
      ST_FETCH: begin
        if (mem.imem_valid) begin
          ir_d    = mem.imem_inst;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DECODE: state_d = dec_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        if (dec_cls == CL_BRANCH)                           state_d = ST_FETCH;
        else if (dec_cls == CL_LOAD || dec_cls == CL_STORE) state_d = ST_MEM;
        else                                                state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem.dmem_ready) begin
          state_d = (dec_cls == CL_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; reset forces every strobe low regardless of state
  always_comb begin
    mem.imem_req   = 1'b0;
    mem.dmem_re    = 1'b0;
    mem.dmem_we    = 1'b0;
    mem.mem_funct3 = 3'b000;
    pc_write       = 1'b0;
    pc_sel         = 1'b0;
    reg_we         = 1'b0;
    imm_sel        = IMM_I;
    a_sel          = A_RS1;
    b_sel          = 1'b0;
    alu_sel        = ALU_ADD;
    wb_sel         = WB_ALU;
    retired        = 1'b0;
    trap           = 1'b0;
    if (reset) begin
      mem.imem_req = (state_q == ST_FETCH);
    end else begin
      case (state_q)
        ST_FETCH: mem.imem_req = 1'b1;
        ST_EXECUTE: begin
          imm_sel = dec_imm;
          a_sel   = dec_a;
          b_sel   = dec_b;
          alu_sel = dec_alu;
          if (dec_cls == CL_BRANCH) begin
            pc_write = 1'b1;
            pc_sel   = br_taken;
            retired  = 1'b1;
          end
        end
        ST_MEM: begin
          mem.dmem_re    = (dec_cls == CL_LOAD);
          mem.dmem_we    = (dec_cls == CL_STORE);
          mem.mem_funct3 = ir_q[14:12];
          imm_sel        = dec_imm;
          a_sel          = A_RS1;
          b_sel          = 1'b1;
          alu_sel        = ALU_ADD;
          // a store's final cycle is the one its memory accepts it
          if (mem.dmem_ready && dec_cls == CL_STORE) begin
            pc_write = 1'b1;
            retired  = 1'b1;
          end
        end
        ST_WB: begin
          // ALU selects stay live so JAL/JALR targets reach the PC mux
          imm_sel  = dec_imm;
          a_sel    = dec_a;
          b_sel    = dec_b;
          alu_sel  = dec_alu;
          wb_sel   = dec_wb;
          reg_we   = (ir_q[11:7] != 5'd0);
          pc_write = 1'b1;
          pc_sel   = (dec_cls == CL_JAL) || (dec_cls == CL_JALR);
          retired  = 1'b1;
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir      = ir_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_klp32_multicycle_ctrl.sv
// Self-checking bench for klp32_multicycle_ctrl: directed cases followed by
// random instruction streams checked against a behavioural model.
module tb_klp32_multicycle_ctrl;
  import klp32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu;
  logic        pc_write, pc_sel, reg_we, b_sel, retired, trap;
  logic [2:0]  imm_sel;
  logic [1:0]  a_sel, wb_sel;
  logic [3:0]  alu_sel;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_instret;
  bit trapped;

  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BRANCH = 4;
  localparam int K_LOAD = 5, K_STORE = 6, K_OPIMM = 7, K_OP = 8, K_BAD = 9;

  typedef struct {
    int         k;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] a;
    logic       b;
    logic [1:0] wb;
  } exp_t;

  logic [3:0] base_op [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  klp32_if mif ();

  klp32_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .INSTRET_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (mif.master),
    .ir       (ir),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .br_ltu   (br_ltu),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .reg_we   (reg_we),
    .imm_sel  (imm_sel),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .alu_sel  (alu_sel),
    .wb_sel   (wb_sel),
    .retired  (retired),
    .instret  (instret),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics from the RV32I opcode map
  function automatic exp_t model(input logic [31:0] in);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = in[14:12];
    f7 = in[31:25];
    e.k = K_BAD; e.alu = ALU_ADD; e.imm = IMM_I; e.a = A_RS1; e.b = 1'b1; e.wb = WB_ALU;
    case (in[6:0])
      7'b0110111: begin e.k = K_LUI;   e.imm = IMM_U; e.a = A_ZERO; end
      7'b0010111: begin e.k = K_AUIPC; e.imm = IMM_U; e.a = A_PC; end
      7'b1101111: begin e.k = K_JAL;   e.imm = IMM_J; e.a = A_PC; e.wb = WB_PC4; end
      7'b1100111: begin e.k = K_JALR;  e.wb = WB_PC4; end
      7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
        e.k = K_BRANCH; e.imm = IMM_B; e.a = A_PC;
      end
      7'b0000011: begin e.k = K_LOAD;  e.wb = WB_MEM; end
      7'b0100011: begin e.k = K_STORE; e.imm = IMM_S; end
      7'b0010011: begin
        e.k = K_OPIMM;
        if (f3 == 3'd5 && f7[5]) e.alu = ALU_SRA;
        else if (f3 != 3'd0)     e.alu = base_op[f3];
      end
      7'b0110011: if (f7 == 7'h00 || f7 == 7'h20) begin
        e.k = K_OP; e.b = 1'b0; e.alu = base_op[f3];
        if (f7[5] && f3 == 3'd0) e.alu = ALU_SUB;
        if (f7[5] && f3 == 3'd5) e.alu = ALU_SRA;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit taken(input logic [2:0] f3, input bit eq, input bit lt, input bit ltu);
    bit c;
    c = f3[2] ? (f3[1] ? ltu : lt) : eq;
    return c ^ f3[0];
  endfunction

  function automatic logic [31:0] gen(input int kind);
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    case (kind)
      0: r[6:0] = 7'b0110111;
      1: r[6:0] = 7'b0010111;
      2: r[6:0] = 7'b1101111;
      3: r[6:0] = 7'b1100111;
      4: begin
        r[6:0] = 7'b1100011;
        do f3 = 3'($urandom); while (f3 == 3'd2 || f3 == 3'd3);
        r[14:12] = f3;
      end
      5: r[6:0] = 7'b0000011;
      6: r[6:0] = 7'b0100011;
      7: r[6:0] = 7'b0010011;
      8: begin r[6:0] = 7'b0110011; r[31:25] = r[31] ? 7'h20 : 7'h00; end
      default: begin
        case ($urandom_range(0, 2))
          0: r[6:0] = 7'b0000000;
          1: begin r[6:0] = 7'b1100011; r[14:12] = 3'd2; end
          default: begin r[6:0] = 7'b0110011; r[31:25] = 7'h01; end
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic trap_hold(input string tag);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk({tag, "_trap"},    32'(trap), 1);
      chk({tag, "_pcw"},     32'(pc_write), 0);
      chk({tag, "_req"},     32'(mif.imem_req), 0);
      chk({tag, "_ret"},     32'(retired), 0);
      chk({tag, "_instret"}, instret, exp_instret);
    end
    trapped = 1'b1;
  endtask

  // Returns in the low phase of the first cycle out of reset (state FETCH)
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mif.imem_valid = 1'b0; mif.dmem_ready = 1'b0;
    #1;
    chk("rst_dmem_we", 32'(mif.dmem_we), 0);
    chk("rst_dmem_re", 32'(mif.dmem_re), 0);
    chk("rst_pcw",     32'(pc_write), 0);
    chk("rst_regwe",   32'(reg_we), 0);
    chk("rst_ret",     32'(retired), 0);
    chk("rst_trap",    32'(trap), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_req",     32'(mif.imem_req), 1);
    chk("post_dmem_we", 32'(mif.dmem_we), 0);
    chk("post_pcw",     32'(pc_write), 0);
    chk("post_trap",    32'(trap), 0);
    chk("post_instret", instret, 0);
    chk("post_ir",      ir, 32'h0000_0013);
    exp_instret = 0;
    trapped     = 1'b0;
  endtask

  // fwait/mwait: idle cycles before imem_valid/dmem_ready; abort>=0 leaves
  // the instruction after that many MEM cycles
  task automatic run_instr(input logic [31:0] inst, input int fwait, input int mwait,
                           input bit eq, input bit lt, input bit ltu, input int abort);
    exp_t e;
    bit   st, ld;
    e  = model(inst);
    st = (e.k == K_STORE);
    ld = (e.k == K_LOAD);
    chk("instret", instret, exp_instret);
    for (int i = 0; i < 100; i++) begin
      mif.imem_valid = (i == fwait);
      mif.imem_inst  = (i == fwait) ? inst : $urandom;
      #1;
      chk("fetch_req", 32'(mif.imem_req), 1);
      chk("fetch_pcw", 32'(pc_write), 0);
      if (i == fwait) break;
      if (i == 15) begin
        @(negedge clk); mif.imem_valid = 1'b0; #1;
        trap_hold("fetch_tmo");
        return;
      end
      @(negedge clk);
    end
    @(negedge clk); mif.imem_valid = 1'b0; #1;
    chk("dec_ir",    ir, inst);
    chk("dec_req",   32'(mif.imem_req), 0);
    chk("dec_pcw",   32'(pc_write), 0);
    chk("dec_regwe", 32'(reg_we), 0);
    @(negedge clk); br_eq = eq; br_lt = lt; br_ltu = ltu; #1;
    if (e.k == K_BAD) begin
      trap_hold("illegal");
      return;
    end
    chk("ex_imm",   32'(imm_sel), 32'(e.imm));
    chk("ex_a",     32'(a_sel), 32'(e.a));
    chk("ex_b",     32'(b_sel), 32'(e.b));
    chk("ex_alu",   32'(alu_sel), 32'(e.alu));
    chk("ex_regwe", 32'(reg_we), 0);
    if (e.k == K_BRANCH) begin
      chk("br_pcw",   32'(pc_write), 1);
      chk("br_pcsel", 32'(pc_sel), 32'(taken(inst[14:12], eq, lt, ltu)));
      chk("br_ret",   32'(retired), 1);
      exp_instret++;
      @(negedge clk);
      return;
    end
    chk("ex_pcw", 32'(pc_write), 0);
    if (st || ld) begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); mif.dmem_ready = (i == mwait); #1;
        chk("mem_re",    32'(mif.dmem_re), 32'(ld));
        chk("mem_we",    32'(mif.dmem_we), 32'(st));
        chk("mem_f3",    32'(mif.mem_funct3), 32'(inst[14:12]));
        chk("mem_a",     32'(a_sel), 32'(A_RS1));
        chk("mem_b",     32'(b_sel), 1);
        chk("mem_alu",   32'(alu_sel), 32'(ALU_ADD));
        chk("mem_imm",   32'(imm_sel), 32'(e.imm));
        chk("mem_regwe", 32'(reg_we), 0);
        chk("mem_pcw",   32'(pc_write), 32'(st && i == mwait));
        chk("mem_ret",   32'(retired), 32'(st && i == mwait));
        if (i == abort) return;
        if (i == mwait) break;
        if (i == 15) begin
          @(negedge clk); mif.dmem_ready = 1'b0; #1;
          trap_hold("mem_tmo");
          return;
        end
      end
      if (st) begin
        exp_instret++;
        @(negedge clk); mif.dmem_ready = 1'b0;
        return;
      end
    end
    @(negedge clk); mif.dmem_ready = 1'b0; #1;
    chk("wb_regwe", 32'(reg_we), 32'(inst[11:7] != 5'd0));
    chk("wb_pcw",   32'(pc_write), 1);
    chk("wb_ret",   32'(retired), 1);
    chk("wb_sel",   32'(wb_sel), 32'(e.wb));
    chk("wb_pcsel", 32'(pc_sel), 32'(e.k == K_JAL || e.k == K_JALR));
    chk("wb_we",    32'(mif.dmem_we), 0);
    if (e.k == K_OPIMM || e.k == K_OP) begin
      chk("wb_b",   32'(b_sel), 32'(e.b));
      chk("wb_alu", 32'(alu_sel), 32'(e.alu));
    end
    exp_instret++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
    mif.imem_valid = 1'b0; mif.imem_inst = 32'd0; mif.dmem_ready = 1'b0;
    exp_instret = 0;
    trapped = 1'b0;
    do_reset();

    run_instr(32'h0050_0093, 0, 0, 0, 0, 0, -1);   // ADDI x1,x0,5
    run_instr(32'h0020_A023, 1, 3, 0, 0, 0, -1);   // SW, ready after 3 waits
    run_instr(32'h0020_8463, 0, 0, 1, 0, 0, -1);   // BEQ taken
    run_instr(32'h0020_8463, 2, 0, 0, 1, 1, -1);   // BEQ not taken
    run_instr(32'h0000_A103, 0, 15, 0, 0, 0, -1);  // LW, ready on last allowed cycle
    run_instr(32'h0000_A103, 0, 40, 0, 0, 0, -1);  // LW, memory never answers
    do_reset();
    run_instr(32'h0000_0013, 16, 0, 0, 0, 0, -1);  // fetch never answers
    do_reset();
    run_instr(32'h0000_0000, 0, 0, 0, 0, 0, -1);   // illegal all-zero word
    do_reset();
    run_instr(32'h0000_006F, 0, 0, 0, 0, 0, -1);   // JAL x0
    run_instr(32'h4020_81B3, 0, 0, 0, 0, 0, -1);   // SUB x3,x1,x2
    run_instr(32'h0020_A023, 0, 10, 0, 0, 0, 2);   // SW aborted by reset
    do_reset();

    for (int n = 0; n < 80; n++) begin
      run_instr(gen($urandom_range(0, 9)), $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
      if (trapped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
